// File: rtl/switch_allocator_pkg.sv
// Shared NoC definitions: port codes, the idle select code and the port-code
// width. The crossbar and routing logic use the same package.
package switch_allocator_pkg;

   localparam int NUM_PORTS = 5;
   localparam int PORT_W    = 3;

   typedef logic [PORT_W-1:0] port_code_t;

   localparam port_code_t PORT_L   = 3'd0;
   localparam port_code_t PORT_N   = 3'd1;
   localparam port_code_t PORT_E   = 3'd2;
   localparam port_code_t PORT_W_C = 3'd3;
   localparam port_code_t PORT_S   = 3'd4;
   localparam port_code_t SEL_IDLE = 3'd5;

   // Round-robin successor, wrapping S back to L.
   function automatic port_code_t next_port(input port_code_t p);
      return (p >= PORT_S) ? PORT_L : port_code_t'(p + 3'd1);
   endfunction

endpackage

// File: rtl/rr_arbiter5.sv
// Five-request arbiter for one crossbar output.
//   req     : request vector, bit index = input port code
//   ptr     : port code holding highest priority (ignored when RR_EN=0)
//   gnt_oh  : one-hot grant
//   gnt_idx : encoded grant, SEL_IDLE when nothing is granted
// With RR_EN=0 the search always starts at L, giving L>N>E>W>S.
module rr_arbiter5
   import switch_allocator_pkg::*;
#(
   parameter int RR_EN = 1
) (
   input  logic [NUM_PORTS-1:0] req,
   input  port_code_t           ptr,
   output logic [NUM_PORTS-1:0] gnt_oh,
   output port_code_t           gnt_idx
);

   port_code_t base;
   logic [3:0] idx;
   logic       found;

   always_comb begin
      gnt_oh  = '0;
      gnt_idx = SEL_IDLE;
      found   = 1'b0;
      idx     = '0;
      base    = ((RR_EN != 0) && (ptr <= PORT_S)) ? ptr : PORT_L;
      for (int i = 0; i < NUM_PORTS; i++) begin
         idx = {1'b0, base} + 4'(i);
         if (idx >= 4'd5) idx = idx - 4'd5;
         if (!found && req[idx[2:0]]) begin
            found               = 1'b1;
            gnt_oh[idx[2:0]]    = 1'b1;
            gnt_idx             = idx[2:0];
         end
      end
   end

endmodule

// File: rtl/switch_allocator.sv
// Wormhole switch allocator for a 5-port router (L, N, E, W, S).
//   clk, rst_n                 : clock, async active-low reset
//   Req_p / Dest_p / Tail_p    : per-input request, destination code, tail flag
//   Grant_p                    : flit on input p moves this cycle
//   Select_o                   : registered owner code of output o (crossbar select)
//   Valid_o                    : output o carries a flit this cycle
//
// Per-output lock state:
//   state    | meaning
//   FREE     | owner_q == SEL_IDLE, requesters for this output arbitrate
//   BUSY(p)  | owner_q == p, input p's flits stream through until its tail
module switch_allocator
   import switch_allocator_pkg::*;
#(
   parameter int RR_EN = 1
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       Req_L,
   input  logic       Req_N,
   input  logic       Req_E,
   input  logic       Req_W,
   input  logic       Req_S,
   input  logic [2:0] Dest_L,
   input  logic [2:0] Dest_N,
   input  logic [2:0] Dest_E,
   input  logic [2:0] Dest_W,
   input  logic [2:0] Dest_S,
   input  logic       Tail_L,
   input  logic       Tail_N,
   input  logic       Tail_E,
   input  logic       Tail_W,
   input  logic       Tail_S,
   output logic       Grant_L,
   output logic       Grant_N,
   output logic       Grant_E,
   output logic       Grant_W,
   output logic       Grant_S,
   output logic [2:0] Select_L,
   output logic [2:0] Select_N,
   output logic [2:0] Select_E,
   output logic [2:0] Select_W,
   output logic [2:0] Select_S,
   output logic       Valid_L,
   output logic       Valid_N,
   output logic       Valid_E,
   output logic       Valid_W,
   output logic       Valid_S
);

   logic [NUM_PORTS-1:0]                req, tail, owns, valid, rel;
   logic [NUM_PORTS-1:0][PORT_W-1:0]    dest;
   logic [NUM_PORTS-1:0][PORT_W-1:0]    owner_q, owner_d, ptr_q, ptr_d, arb_idx;
   logic [NUM_PORTS-1:0][NUM_PORTS-1:0] own_mat, arb_req, arb_oh;

   assign req  = {Req_S, Req_W, Req_E, Req_N, Req_L};
   assign tail = {Tail_S, Tail_W, Tail_E, Tail_N, Tail_L};
   assign dest = {Dest_S, Dest_W, Dest_E, Dest_N, Dest_L};

   // Ownership decode; an input that already owns an output never competes
   // for another, and only FREE outputs take requests. Dest codes >= 5 never
   // match an output index so they are ignored here.
   always_comb begin
      own_mat = '0;
      owns    = '0;
      valid   = '0;
      rel     = '0;
      arb_req = '0;
      for (int o = 0; o < NUM_PORTS; o++) begin
         for (int p = 0; p < NUM_PORTS; p++) begin
            if (owner_q[o] == port_code_t'(p)) begin
               own_mat[p][o] = 1'b1;
               valid[o]      = req[p];
               rel[o]        = req[p] & tail[p];
            end
         end
      end
      for (int p = 0; p < NUM_PORTS; p++) owns[p] = |own_mat[p];
      for (int o = 0; o < NUM_PORTS; o++) begin
         for (int p = 0; p < NUM_PORTS; p++) begin
            arb_req[o][p] = req[p] && (dest[p] == port_code_t'(o)) && !owns[p]
                            && (owner_q[o] == SEL_IDLE);
         end
      end
   end

   for (genvar o = 0; o < NUM_PORTS; o++) begin : g_arb
      rr_arbiter5 #(.RR_EN(RR_EN)) u_arb (
         .req     (arb_req[o]),
         .ptr     (ptr_q[o]),
         .gnt_oh  (arb_oh[o]),
         .gnt_idx (arb_idx[o])
      );
   end

   // Pointer moves only when a new lock is taken.
   always_comb begin
      owner_d = owner_q;
      ptr_d   = ptr_q;
      for (int o = 0; o < NUM_PORTS; o++) begin
         if (owner_q[o] == SEL_IDLE) begin
            if (|arb_oh[o]) begin
               owner_d[o] = arb_idx[o];
               ptr_d[o]   = next_port(arb_idx[o]);
            end
         end else if (rel[o]) begin
            owner_d[o] = SEL_IDLE;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         owner_q <= {NUM_PORTS{SEL_IDLE}};
         ptr_q   <= {NUM_PORTS{PORT_L}};
      end else begin
         owner_q <= owner_d;
         ptr_q   <= ptr_d;
      end
   end

   assign {Grant_S, Grant_W, Grant_E, Grant_N, Grant_L} = owns & req;
   assign {Valid_S, Valid_W, Valid_E, Valid_N, Valid_L} = valid;
   assign Select_L = owner_q[0];
   assign Select_N = owner_q[1];
   assign Select_E = owner_q[2];
   assign Select_W = owner_q[3];
   assign Select_S = owner_q[4];

   for (genvar p = 0; p < NUM_PORTS; p++) begin : g_chk
      a_dest_stable: assert property (@(posedge clk) disable iff (!rst_n)
         (req[p] && $past(req[p])) |-> (dest[p] == $past(dest[p])));
      a_one_owner: assert property (@(posedge clk) disable iff (!rst_n)
         $onehot0(own_mat[p]));
   end

endmodule

// File: tb/tb_switch_allocator.sv
module tb_switch_allocator;

   logic clk = 1'b0;
   logic rst_n;
   logic [4:0] req, tail;
   logic [4:0][2:0] dest;

   logic [4:0] g_rr, v_rr, g_fp, v_fp;
   logic [4:0][2:0] s_rr, s_fp;

   int checks = 0;
   int errors = 0;

   localparam logic [14:0] IDLE15 = {5{3'd5}};
   localparam logic [2:0] RR_SEL [6] = '{3'd5, 3'd0, 3'd5, 3'd1, 3'd5, 3'd2};
   localparam logic [2:0] FP_SEL [6] = '{3'd5, 3'd0, 3'd5, 3'd0, 3'd5, 3'd0};
   localparam logic [4:0] RR_GNT [6] = '{5'd0, 5'd1, 5'd0, 5'd2, 5'd0, 5'd4};
   localparam logic [4:0] FP_GNT [6] = '{5'd0, 5'd1, 5'd0, 5'd1, 5'd0, 5'd1};

   always #5 clk = ~clk;

   switch_allocator #(.RR_EN(1)) dut (
      .clk(clk), .rst_n(rst_n),
      .Req_L(req[0]), .Req_N(req[1]), .Req_E(req[2]), .Req_W(req[3]), .Req_S(req[4]),
      .Dest_L(dest[0]), .Dest_N(dest[1]), .Dest_E(dest[2]), .Dest_W(dest[3]), .Dest_S(dest[4]),
      .Tail_L(tail[0]), .Tail_N(tail[1]), .Tail_E(tail[2]), .Tail_W(tail[3]), .Tail_S(tail[4]),
      .Grant_L(g_rr[0]), .Grant_N(g_rr[1]), .Grant_E(g_rr[2]), .Grant_W(g_rr[3]), .Grant_S(g_rr[4]),
      .Select_L(s_rr[0]), .Select_N(s_rr[1]), .Select_E(s_rr[2]), .Select_W(s_rr[3]), .Select_S(s_rr[4]),
      .Valid_L(v_rr[0]), .Valid_N(v_rr[1]), .Valid_E(v_rr[2]), .Valid_W(v_rr[3]), .Valid_S(v_rr[4])
   );

   switch_allocator #(.RR_EN(0)) dut_fp (
      .clk(clk), .rst_n(rst_n),
      .Req_L(req[0]), .Req_N(req[1]), .Req_E(req[2]), .Req_W(req[3]), .Req_S(req[4]),
      .Dest_L(dest[0]), .Dest_N(dest[1]), .Dest_E(dest[2]), .Dest_W(dest[3]), .Dest_S(dest[4]),
      .Tail_L(tail[0]), .Tail_N(tail[1]), .Tail_E(tail[2]), .Tail_W(tail[3]), .Tail_S(tail[4]),
      .Grant_L(g_fp[0]), .Grant_N(g_fp[1]), .Grant_E(g_fp[2]), .Grant_W(g_fp[3]), .Grant_S(g_fp[4]),
      .Select_L(s_fp[0]), .Select_N(s_fp[1]), .Select_E(s_fp[2]), .Select_W(s_fp[3]), .Select_S(s_fp[4]),
      .Valid_L(v_fp[0]), .Valid_N(v_fp[1]), .Valid_E(v_fp[2]), .Valid_W(v_fp[3]), .Valid_S(v_fp[4])
   );

   function automatic logic [14:0] sel5(input logic [2:0] l, n, e, w, s);
      return {s, w, e, n, l};
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Check one cycle of the round-robin DUT, then move to the next cycle.
   task automatic cyc(input string tag, input logic [4:0] ge, input logic [4:0] ve,
                      input logic [14:0] se);
      @(negedge clk);
      chk({tag, "_grant"}, 32'(g_rr), 32'(ge));
      chk({tag, "_valid"}, 32'(v_rr), 32'(ve));
      chk({tag, "_select"}, 32'(s_rr), 32'(se));
      @(posedge clk); #1;
   endtask

   task automatic clear_inputs();
      req  = '0;
      tail = '0;
      dest = '0;
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      clear_inputs();
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
   endtask

   initial begin
      rst_n = 1'b0;
      clear_inputs();

      // Reset state
      @(negedge clk);
      chk("rst_select", 32'(s_rr), 32'(IDLE15));
      chk("rst_grant", 32'(g_rr), 32'd0);
      chk("rst_valid", 32'(v_rr), 32'd0);
      do_reset();

      // Contention on E-out, single-flit packets, requests held continuously
      req[2:0] = 3'b111;
      dest[0] = 3'd2; dest[1] = 3'd2; dest[2] = 3'd2;
      tail[2:0] = 3'b111;
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         chk("cont_rr_sel", 32'(s_rr[2]), 32'(RR_SEL[i]));
         chk("cont_rr_grant", 32'(g_rr), 32'(RR_GNT[i]));
         chk("cont_fp_sel", 32'(s_fp[2]), 32'(FP_SEL[i]));
         chk("cont_fp_grant", 32'(g_fp), 32'(FP_GNT[i]));
         @(posedge clk); #1;
      end
      do_reset();

      // Wormhole: W sends 4 flits to N, S requests N from flit 2
      req[3] = 1'b1; dest[3] = 3'd1;
      cyc("worm_t0", 5'b00000, 5'b00000, IDLE15);
      cyc("worm_t1", 5'b01000, 5'b00010, sel5(3'd5, 3'd3, 3'd5, 3'd5, 3'd5));
      req[4] = 1'b1; dest[4] = 3'd1;
      cyc("worm_t2", 5'b01000, 5'b00010, sel5(3'd5, 3'd3, 3'd5, 3'd5, 3'd5));
      cyc("worm_t3", 5'b01000, 5'b00010, sel5(3'd5, 3'd3, 3'd5, 3'd5, 3'd5));
      tail[3] = 1'b1;
      cyc("worm_t4", 5'b01000, 5'b00010, sel5(3'd5, 3'd3, 3'd5, 3'd5, 3'd5));
      req[3] = 1'b0; tail[3] = 1'b0;
      cyc("worm_t5", 5'b00000, 5'b00000, IDLE15);
      tail[4] = 1'b1;
      cyc("worm_t6", 5'b10000, 5'b00010, sel5(3'd5, 3'd4, 3'd5, 3'd5, 3'd5));
      req[4] = 1'b0; tail[4] = 1'b0;
      cyc("worm_t7", 5'b00000, 5'b00000, IDLE15);
      do_reset();

      // Stall: L owns W-out, drops Req for 3 cycles; N competes
      req[0] = 1'b1; dest[0] = 3'd3;
      cyc("stall_t0", 5'b00000, 5'b00000, IDLE15);
      cyc("stall_t1", 5'b00001, 5'b01000, sel5(3'd5, 3'd5, 3'd5, 3'd0, 3'd5));
      req[0] = 1'b0; req[1] = 1'b1; dest[1] = 3'd3;
      cyc("stall_t2", 5'b00000, 5'b00000, sel5(3'd5, 3'd5, 3'd5, 3'd0, 3'd5));
      cyc("stall_t3", 5'b00000, 5'b00000, sel5(3'd5, 3'd5, 3'd5, 3'd0, 3'd5));
      cyc("stall_t4", 5'b00000, 5'b00000, sel5(3'd5, 3'd5, 3'd5, 3'd0, 3'd5));
      req[0] = 1'b1; tail[0] = 1'b1;
      cyc("stall_t5", 5'b00001, 5'b01000, sel5(3'd5, 3'd5, 3'd5, 3'd0, 3'd5));
      req[0] = 1'b0; tail[0] = 1'b0;
      cyc("stall_t6", 5'b00000, 5'b00000, IDLE15);
      tail[1] = 1'b1;
      cyc("stall_t7", 5'b00010, 5'b01000, sel5(3'd5, 3'd5, 3'd5, 3'd1, 3'd5));
      do_reset();

      // Parallel: L->N, N->E, E->W, W->S, S->L
      req = 5'b11111; tail = 5'b11111;
      dest = {3'd0, 3'd4, 3'd3, 3'd2, 3'd1};
      cyc("par_t0", 5'b00000, 5'b00000, IDLE15);
      cyc("par_t1", 5'b11111, 5'b11111, sel5(3'd4, 3'd0, 3'd1, 3'd2, 3'd3));
      req = '0; tail = '0;
      cyc("par_t2", 5'b00000, 5'b00000, IDLE15);
      do_reset();

      // Invalid destination ignored for 10 cycles
      req[0] = 1'b1; dest[0] = 3'd6;
      for (int i = 0; i < 10; i++) cyc("bad_dest", 5'b00000, 5'b00000, IDLE15);
      req[0] = 1'b0;
      cyc("bad_dest_after", 5'b00000, 5'b00000, IDLE15);
      do_reset();

      // Reset mid-packet: outputs clear in the same cycle, lock not resumed
      req[0] = 1'b1; dest[0] = 3'd2;
      cyc("rstmid_t0", 5'b00000, 5'b00000, IDLE15);
      cyc("rstmid_t1", 5'b00001, 5'b00100, sel5(3'd5, 3'd5, 3'd0, 3'd5, 3'd5));
      #2 rst_n = 1'b0;
      #1;
      chk("rstmid_select", 32'(s_rr), 32'(IDLE15));
      chk("rstmid_grant", 32'(g_rr), 32'd0);
      chk("rstmid_valid", 32'(v_rr), 32'd0);
      req[0] = 1'b0;
      @(posedge clk); #1;
      rst_n = 1'b1;
      cyc("rstmid_after", 5'b00000, 5'b00000, IDLE15);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
